right_shift_unit: RTL and testbench
===================================

// Module: right_shift_unit
// PURPOSE
//   Multi-cycle right shifter for the CPU execute stage, implementing SRL/SRLV/SRA/SRAV.
//   Complements the combinational left-by-2 address shifter with the opposite shift direction.
//   Shifts iteratively, STEP bits per cycle, to save area.
//   Uses a start/busy/done handshake so the control unit can stall while a shift runs.
// PARAMETERS
//   WIDTH  32  data width in bits
//   SW     5   shift-amount width (log2 WIDTH)
//   STEP   1   max bits shifted per SHIFT cycle; legal values 1, 2, 4, 8
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request pulse; accepted only in IDLE
//   arith  in   1      1 = arithmetic (sign-fill), 0 = logical (zero-fill); sampled at accept
//   din    in   WIDTH  operand; sampled at accept
//   shamt  in   SW     shift amount 0..WIDTH-1; sampled at accept
//   busy   out  1      high in SHIFT and DONE states
//   done   out  1      one-cycle pulse; dout valid in the same cycle
//   dout   out  WIDTH  result; holds its value until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, dout=0; internal counter and sign flag cleared.
//   Reset wins over every other input in the same cycle, including mid-operation; no done is emitted.
//   Registers: acc (WIDTH bits), cnt (SW bits), sgn (1 bit) = arith & din[WIDTH-1].
//   Accept: in IDLE with start=1, load acc=din, cnt=shamt, latch sgn.
//     Next state is SHIFT if shamt!=0, otherwise DONE.
//   SHIFT: each cycle, k = min(cnt, STEP).
//     acc <= {k copies of sgn, acc[WIDTH-1:k]}; cnt <= cnt-k.
//     Go to DONE when cnt-k==0.
//   DONE: done=1, dout=acc (dout is registered on the DONE transition). Next state is IDLE.
//   start while busy=1 is ignored: no queueing, no error.
//   In IDLE the operand inputs may change freely; they are only sampled at accept.
//   Latency: done rises ceil(shamt/STEP)+1 cycles after the accept edge.
//     shamt=0 gives 1 cycle and dout=din.
//   Throughput: back-to-back start is possible in the cycle after DONE (IDLE).
//   arith=1 with din[WIDTH-1]=0 gives the same result as a logical shift.
//   Maximum shift: shamt=WIDTH-1 is legal and has no wrap.
//     With STEP=1 this gives WIDTH cycles of latency (WIDTH-1 SHIFT cycles plus DONE).
//   States are encoded in 2 bits; the unused encoding returns to IDLE with busy=0 and done=0.
// TESTING
//   1. SRL din=0x80000000, shamt=31, arith=0, STEP=1 -> done at +32 cycles, dout=0x00000001.
//   2. SRA din=0x80000000, shamt=4, arith=1 -> done at +5 cycles, dout=0xF8000000.
//   3. shamt=0, din=0xDEADBEEF, either arith -> done at +1 cycle, dout=0xDEADBEEF, busy high for 1 cycle.
//   4. Second start pulsed during SHIFT (din=0x1234) -> ignored; first result correct; a start in the cycle after done is accepted.
//   5. rst asserted during SHIFT -> next cycle busy=0, done=0, dout=0; no done pulse follows.
//   6. STEP=4, SRA din=0xF0000000, shamt=7 -> done at +3 cycles (4+3 bits), dout=0xFFE00000.
//   All cases: compare against a reference model (>> and $signed >>>) over 1000 random din/shamt/arith.

Source files
------------

// File: rtl/right_shift_unit_if.sv
// Handshake and data bundle between the execute-stage control unit and the
// multi-cycle right shifter.
interface right_shift_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 5
) ();
    logic             start;
    logic             arith;
    logic [WIDTH-1:0] din;
    logic [SW-1:0]    shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, arith, din, shamt,
        input  busy, done, dout
    );

    modport slave (
        input  start, arith, din, shamt,
        output busy, done, dout
    );
endinterface

// File: rtl/right_shift_unit.sv
// Iterative right shifter (SRL/SRLV/SRA/SRAV). Moves at most STEP bits per
// cycle and reports completion with a one-cycle done pulse; dout holds its
// value between results.
module right_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW    = 5,
    parameter int unsigned STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    right_shift_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [SW-1:0]    STEP_C = SW'(STEP);
    localparam logic [WIDTH-1:0] ONES   = '1;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] dout_q;
    logic [SW-1:0]    cnt_q;
    logic             sgn_q;
    logic             busy_q;
    logic             done_q;

    logic [SW-1:0]    k_d;
    logic [SW-1:0]    cnt_d;
    logic [WIDTH-1:0] acc_d;

    // One shift step: move by min(cnt, STEP) bits, filling the vacated
    // top bits with the latched sign (zero for logical shifts).
    always_comb begin
        k_d   = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        cnt_d = cnt_q - k_d;
        acc_d = acc_q >> k_d;
        if (sgn_q) begin
            acc_d = acc_d | ~(ONES >> k_d);
        end
    end

    // Control FSM with registered busy/done/dout; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        acc_q  <= bus.din;
                        cnt_q  <= bus.shamt;
                        sgn_q  <= bus.arith & bus.din[WIDTH-1];
                        busy_q <= 1'b1;
                        if (bus.shamt != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dout_q  <= bus.din;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        dout_q  <= acc_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_right_shift_unit.sv
// Bench for right_shift_unit: drives identical requests into a STEP=1 and a
// STEP=4 instance and checks both against a cycle-level result/latency model.
module tb_right_shift_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_r = 1'b0;
    logic        arith_r = 1'b0;
    logic [31:0] din_r = '0;
    logic [4:0]  shamt_r = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    right_shift_unit_if #(.WIDTH(32), .SW(5)) bus1 ();
    right_shift_unit_if #(.WIDTH(32), .SW(5)) bus4 ();

    assign bus1.start = start_r;
    assign bus1.arith = arith_r;
    assign bus1.din   = din_r;
    assign bus1.shamt = shamt_r;
    assign bus4.start = start_r;
    assign bus4.arith = arith_r;
    assign bus4.din   = din_r;
    assign bus4.shamt = shamt_r;

    right_shift_unit #(.WIDTH(32), .SW(5), .STEP(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    right_shift_unit #(.WIDTH(32), .SW(5), .STEP(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic a, input logic [31:0] d, input logic [4:0] s);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    // Model: r = cycles left until the end of the done cycle (0 = idle).
    int          r [2];
    logic [31:0] pend [2];
    logic [31:0] exp_dout [2];
    bit          mvalid = 1'b0;
    int          steps [2] = '{1, 4};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                r[i]        = 0;
                exp_dout[i] = '0;
            end else begin
                if (r[i] == 0) begin
                    if (start_r) begin
                        pend[i] = ref_shift(arith_r, din_r, shamt_r);
                        r[i]    = (int'(shamt_r) + steps[i] - 1) / steps[i] + 1;
                    end
                end else begin
                    r[i]--;
                end
                if (r[i] == 1) exp_dout[i] = pend[i];
            end
        end
        if (rst) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("busy1", 32'(bus1.busy), 32'(r[0] != 0));
            chk("done1", 32'(bus1.done), 32'(r[0] == 1));
            chk("dout1", bus1.dout, exp_dout[0]);
            chk("busy4", 32'(bus4.busy), 32'(r[1] != 0));
            chk("done4", 32'(bus4.done), 32'(r[1] == 1));
            chk("dout4", bus4.dout, exp_dout[1]);
        end
    end

    // Issue one request from a negedge; return at the negedge of the idle
    // cycle following the later done, so the next call is back-to-back.
    task automatic run_op(input logic a, input logic [31:0] d, input logic [4:0] s,
                          input bit lit, input logic [31:0] exp_d,
                          input int exp_l1, input int exp_l4, input bit inject);
        int c;
        int l1;
        int l4;
        logic [31:0] d1;
        logic [31:0] d4;
        arith_r = a;
        din_r   = d;
        shamt_r = s;
        start_r = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r = 1'b0;
        din_r   = $urandom;
        shamt_r = 5'($urandom);
        arith_r = ~a;
        c  = 1;
        l1 = 0;
        l4 = 0;
        d1 = '0;
        d4 = '0;
        while ((l1 == 0 || l4 == 0) && c < 100) begin
            if (bus1.done && l1 == 0) begin l1 = c; d1 = bus1.dout; end
            if (bus4.done && l4 == 0) begin l4 = c; d4 = bus4.dout; end
            if (inject && c == 3) begin
                start_r = 1'b1;
                din_r   = 32'h0000_1234;
                shamt_r = 5'd0;
            end else begin
                start_r = 1'b0;
            end
            if (l1 == 0 || l4 == 0) begin
                @(negedge clk);
                c++;
            end
        end
        start_r = 1'b0;
        chk("timeout", {30'd0, l1 != 0, l4 != 0}, 32'd3);
        if (lit) begin
            chk("lat1", 32'(l1), 32'(exp_l1));
            chk("lat4", 32'(l4), 32'(exp_l4));
            chk("res1", d1, exp_d);
            chk("res4", d4, exp_d);
        end
        @(negedge clk);
        if (lit) begin
            chk("idle1", 32'(bus1.busy), 32'd0);
            chk("idle4", 32'(bus4.busy), 32'd0);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_done", 32'(bus1.done), 32'd0);
        chk("rst_dout", bus4.dout, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // SRL max shift
        run_op(1'b0, 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, 32, 9, 1'b0);
        // SRA by 4
        run_op(1'b1, 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, 5, 2, 1'b0);
        // zero shift, both polarities
        run_op(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 1, 1, 1'b0);
        run_op(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF, 1, 1, 1'b0);
        // STEP=4 partial last step
        run_op(1'b1, 32'hF000_0000, 5'd7, 1'b1, 32'hFFE0_0000, 8, 3, 1'b0);
        // arithmetic with positive operand behaves logically
        run_op(1'b1, 32'h7000_0000, 5'd4, 1'b1, 32'h0700_0000, 5, 2, 1'b0);
        // equal latencies, consecutive requests accepted back-to-back
        run_op(1'b1, 32'h8000_0001, 5'd1, 1'b1, 32'hC000_0000, 2, 2, 1'b0);
        run_op(1'b0, 32'h8000_0001, 5'd1, 1'b1, 32'h4000_0000, 2, 2, 1'b0);
        // start during SHIFT is ignored
        run_op(1'b0, 32'hABCD_0000, 5'd20, 1'b1, 32'h0000_0ABC, 21, 6, 1'b1);

        // reset in the middle of a shift
        arith_r = 1'b1;
        din_r   = 32'h8000_0000;
        shamt_r = 5'd20;
        start_r = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy1", 32'(bus1.busy), 32'd0);
        chk("mid_rst_done1", 32'(bus1.done), 32'd0);
        chk("mid_rst_dout1", bus1.dout, 32'd0);
        chk("mid_rst_busy4", 32'(bus4.busy), 32'd0);
        chk("mid_rst_dout4", bus4.dout, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.done || bus4.done) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);

        for (int n = 0; n < 1000; n++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                   1'b0, 32'd0, 0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
